// File: rtl/inst_fetch_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding read at a time, hands each fetched
// word to decode and picks the next PC from decode's select when decode accepts it.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         PC_s,
  input  logic [15:0]        imm_offset,
  input  logic [25:0]        address,
  input  logic [31:0]        rs_data,
  input  logic               stall,
  inst_fetch_if.master       imem,
  output logic [31:0]        Inst_code,
  output logic               inst_valid,
  output logic [31:0]        PC,
  output logic               addr_err,
  output logic [31:0]        inst_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        advance;
  logic        misaligned;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;

  // State register; reset always parks the unit in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: IDLE only lasts one cycle, FETCH waits for ack, ISSUE waits for decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem.imem_ack) state_next = ISSUE;
      ISSUE:   if (!stall) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Datapath decode: acceptance/advance strobes and the next-PC selection.
  always_comb begin
    accept     = (state == FETCH) && imem.imem_ack;
    advance    = (state == ISSUE) && !stall;
    pc_plus4   = PC + 32'd4;
    pc_target  = pc_plus4;
    case (PC_s)
      2'b00: pc_target = pc_plus4;
      2'b01: pc_target = pc_plus4 + {{14{imm_offset[15]}}, imm_offset, 2'b00};
      2'b10: pc_target = {pc_plus4[31:28], address, 2'b00};
      2'b11: pc_target = {rs_data[31:2], 2'b00};
      default: pc_target = pc_plus4;
    endcase
    misaligned = advance && (PC_s == 2'b11) && (rs_data[1:0] != 2'b00);
  end

  // Registered outputs; the request rises one cycle after FETCH is first entered from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC             <= RESET_PC;
      imem.imem_addr <= RESET_PC;
      imem.imem_req  <= 1'b0;
      inst_valid     <= 1'b0;
      Inst_code      <= 32'h0;
      addr_err       <= 1'b0;
      inst_cnt       <= 32'h0;
    end else begin
      if (state == FETCH) begin
        if (accept) begin
          Inst_code     <= imem.imem_rdata;
          inst_valid    <= 1'b1;
          imem.imem_req <= 1'b0;
        end else begin
          imem.imem_req <= 1'b1;
        end
      end
      if (advance) begin
        PC             <= pc_target;
        imem.imem_addr <= pc_target;
        inst_cnt       <= inst_cnt + 32'd1;
        inst_valid     <= 1'b0;
        imem.imem_req  <= 1'b1;
      end
      if (misaligned) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  PC_s = 2'b00;
  logic [15:0] imm_offset = 16'h0;
  logic [25:0] address = 26'h0;
  logic [31:0] rs_data = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] Inst_code;
  logic        inst_valid;
  logic [31:0] PC;
  logic        addr_err;
  logic [31:0] inst_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] expCnt = 32'h0;
  logic [31:0] expPc = 32'h0;
  logic        expErr = 1'b0;
  logic [31:0] heldCode;

  inst_fetch_if imem_bus ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC_s       (PC_s),
    .imm_offset (imm_offset),
    .address    (address),
    .rs_data    (rs_data),
    .stall      (stall),
    .imem       (imem_bus),
    .Inst_code  (Inst_code),
    .inst_valid (inst_valid),
    .PC         (PC),
    .addr_err   (addr_err),
    .inst_cnt   (inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Hold ack low for 'waits' cycles while the request is up, then return 'word'.
  task automatic doFetch(input int waits, input logic [31:0] word);
    for (int i = 0; i < waits; i++) begin
      checkOutput("wait_req", {31'b0, imem_bus.imem_req}, 32'h1);
      checkOutput("wait_valid", {31'b0, inst_valid}, 32'h0);
      step();
    end
    checkOutput("fetch_addr", imem_bus.imem_addr, expPc);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    step();
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    checkOutput("issue_code", Inst_code, word);
    checkOutput("issue_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("issue_req", {31'b0, imem_bus.imem_req}, 32'h0);
    checkOutput("issue_pc", PC, expPc);
  endtask

  // Release the issued instruction with the given next-PC select; newPc is hand-computed.
  task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] imm, input logic [25:0] tgt,
                               input logic [31:0] rs, input logic [31:0] newPc, input logic errAfter);
    PC_s       = sel;
    imm_offset = imm;
    address    = tgt;
    rs_data    = rs;
    stall      = 1'b0;
    step();
    PC_s       = ~sel;
    imm_offset = 16'h5A5A;
    address    = 26'h3FF_FFFF;
    rs_data    = 32'h1234_5677;
    expCnt     = expCnt + 32'd1;
    expPc      = newPc;
    expErr     = errAfter;
    checkOutput("adv_pc", PC, expPc);
    checkOutput("adv_addr", imem_bus.imem_addr, expPc);
    checkOutput("adv_req", {31'b0, imem_bus.imem_req}, 32'h1);
    checkOutput("adv_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("adv_cnt", inst_cnt, expCnt);
    checkOutput("adv_err", {31'b0, addr_err}, {31'b0, expErr});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc"}, PC, 32'h0);
    checkOutput({tag, "_addr"}, imem_bus.imem_addr, 32'h0);
    checkOutput({tag, "_req"}, {31'b0, imem_bus.imem_req}, 32'h0);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
    checkOutput({tag, "_code"}, Inst_code, 32'h0);
    checkOutput({tag, "_err"}, {31'b0, addr_err}, 32'h0);
    checkOutput({tag, "_cnt"}, inst_cnt, 32'h0);
  endtask

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    #1 rst = 1'b1;
    step();
    step();
    checkResetState("rst");

    rst = 1'b0;
    step();
    checkOutput("post_rst_edge1_req", {31'b0, imem_bus.imem_req}, 32'h0);
    step();
    checkOutput("post_rst_edge2_req", {31'b0, imem_bus.imem_req}, 32'h1);
    checkOutput("post_rst_edge2_addr", imem_bus.imem_addr, 32'h0);
    doFetch(3, 32'h0022_1820);

    applyStimulus(2'b10, 16'h0, 26'h000_0004, 32'h0, 32'h0000_0010, 1'b0);
    doFetch(1, 32'h1111_0001);
    applyStimulus(2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0014, 1'b0);
    doFetch(0, 32'h1111_0002);
    applyStimulus(2'b10, 16'h0, 26'h000_0040, 32'h0, 32'h0000_0100, 1'b0);
    doFetch(2, 32'h1111_0003);
    applyStimulus(2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h0000_00FC, 1'b0);
    doFetch(0, 32'h1111_0004);
    applyStimulus(2'b11, 16'h0, 26'h0, 32'h4000_0000, 32'h4000_0000, 1'b0);
    doFetch(0, 32'h1111_0005);
    applyStimulus(2'b10, 16'h0, 26'h000_0010, 32'h0, 32'h4000_0040, 1'b0);
    doFetch(1, 32'h1111_0006);
    applyStimulus(2'b11, 16'h0, 26'h0, 32'h0000_0203, 32'h0000_0200, 1'b1);
    doFetch(0, 32'h1111_0007);
    applyStimulus(2'b01, 16'h0003, 26'h0, 32'h0, 32'h0000_0210, 1'b1);
    doFetch(0, 32'h1111_0008);
    applyStimulus(2'b11, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    doFetch(0, 32'h1111_0009);
    applyStimulus(2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0000, 1'b1);
    doFetch(0, 32'h1111_000A);
    applyStimulus(2'b01, 16'h8000, 26'h0, 32'h0, 32'hFFFE_0004, 1'b1);
    doFetch(0, 32'h1111_000B);

    heldCode = 32'h1111_000B;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_bus.imem_ack   = (i % 2 == 0);
      imem_bus.imem_rdata = 32'hBAD0_0000 + i;
      step();
      checkOutput("stall_req", {31'b0, imem_bus.imem_req}, 32'h0);
      checkOutput("stall_code", Inst_code, heldCode);
      checkOutput("stall_valid", {31'b0, inst_valid}, 32'h1);
      checkOutput("stall_pc", PC, 32'hFFFE_0004);
      checkOutput("stall_cnt", inst_cnt, expCnt);
    end
    imem_bus.imem_ack = 1'b0;
    applyStimulus(2'b00, 16'h0, 26'h0, 32'h0, 32'hFFFE_0008, 1'b1);

    #2 rst = 1'b1;
    #1 checkResetState("mid_fetch_rst");
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hCAFE_F00D;
    step();
    rst = 1'b0;
    step();
    checkOutput("late_ack_code", Inst_code, 32'h0);
    checkOutput("late_ack_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("late_ack_req", {31'b0, imem_bus.imem_req}, 32'h0);
    imem_bus.imem_ack = 1'b0;
    step();
    expPc  = 32'h0;
    expCnt = 32'h0;
    checkOutput("refetch_req", {31'b0, imem_bus.imem_req}, 32'h1);
    doFetch(0, 32'h0123_4567);
    checkOutput("refetch_cnt", inst_cnt, 32'h0);
    checkOutput("refetch_err", {31'b0, addr_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset; SHALL be word-aligned.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 PC_s  input  2  next-PC select from the decode stage.
REQ-005 imm_offset  input  16  branch offset in words, signed.
REQ-006 address  input  26  jump target field.
REQ-007 rs_data  input  32  register-jump target.
REQ-008 stall  input  1  downstream not ready; hold current instruction.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  32  instruction-memory read address.
REQ-011 imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-012 imem_ack  input  1  instruction-memory read completion, one-cycle pulse.
REQ-013 Inst_code  output  32  fetched instruction (OP+rs+rt+rd+shamt+func) to decode.
REQ-014 inst_valid  output  1  Inst_code holds a valid instruction.
REQ-015 PC  output  32  address of the instruction in Inst_code.
REQ-016 addr_err  output  1  sticky flag: misaligned register-jump target seen.
REQ-017 inst_cnt  output  32  count of instructions issued to decode.

Function
REQ-018 State machine: IDLE, FETCH, ISSUE; all outputs SHALL be registered.
REQ-019 IDLE -> FETCH unconditionally on the next edge; IDLE is entered only from reset.
REQ-020 In FETCH: imem_req=1, imem_addr=PC, inst_valid=0; wait states of any length SHALL be tolerated.
REQ-021 In FETCH with imem_ack=1: Inst_code<=imem_rdata, inst_valid<=1, imem_req<=0, go to ISSUE.
REQ-022 imem_ack outside FETCH SHALL be ignored; Inst_code SHALL not change.
REQ-023 In ISSUE with stall=1: hold Inst_code, PC and inst_valid unchanged.
REQ-024 In ISSUE with stall=0: update PC per REQ-025, inst_cnt+=1, inst_valid<=0, imem_req<=1, go to FETCH.
REQ-025 Next PC, mod 2^32, with p4=PC+4:
- 00 -> p4
- 01 -> p4 + (sign_extend(imm_offset)<<2)
- 10 -> {p4[31:28], address, 2'b00}
- 11 -> {rs_data[31:2], 2'b00}
REQ-026 PC_s=11 with rs_data[1:0]!=0 SHALL set addr_err=1; addr_err SHALL clear only on reset.
REQ-027 PC and branch arithmetic SHALL wrap at 2^32 without any flag; inst_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 One instruction in flight at most; imem_req SHALL not be asserted while in ISSUE.
REQ-029 PC_s, imm_offset, address and rs_data SHALL be sampled only on the ISSUE->FETCH edge.

Reset
REQ-030 rst=1 SHALL immediately force:
- state=IDLE, PC=RESET_PC, imem_addr=RESET_PC
- imem_req=0, inst_valid=0, Inst_code=0
- addr_err=0, inst_cnt=0
REQ-031 Reset asserted mid-fetch SHALL abandon the request; a later imem_ack SHALL be ignored until FETCH is re-entered.
REQ-032 After rst deasserts: first imem_req=1 SHALL appear on the second rising edge, with imem_addr=RESET_PC.

Verification
REQ-033 Reset, then ack with 0x00221820 after 3 wait cycles -> Inst_code=0x00221820, inst_valid=1, PC=0.
REQ-034 Sequential fetch:
- stimulus: PC=0x10, PC_s=00, stall=0
- required: next imem_addr=0x14, inst_cnt increments by 1.
REQ-035 Branch: PC=0x100, PC_s=01, imm_offset=16'hFFFE -> PC=0xFC.
REQ-036 Jump, then register jump:
- PC=0x40000000, PC_s=10, address=26'h10 -> PC=0x40000040
- PC_s=11, rs_data=0x203 -> PC=0x200, addr_err=1 and held.
REQ-037 Stall and reset:
- stall=1 for 5 cycles in ISSUE -> no imem_req, Inst_code stable.
- rst pulsed during FETCH -> all outputs at reset values in the same cycle.
